rv_fifo_buffer: RTL
===================

Name: rv_fifo_buffer

Overview:
- Ready/valid FIFO buffer inserted between the 8-bit generator stage and the checker stage on the data path.
- Consumes the generator's output_port_* stream and presents an equivalent stream to the checker.
- Fully decouples the two sides: no combinational path from output_port_ready to input_port_ready.
- Exposes its occupancy so benches can check throughput and backpressure.

Parameters:
- DATA_WIDTH, 8, width of the data payload.
- DEPTH, 4, number of entries; power of two, minimum 2.

Ports:
- clock_port  input  1  single clock; all state updates on its rising edge.
- reset_port  input  1  synchronous, active-high reset.
- input_port_data  input  DATA_WIDTH  upstream payload.
- input_port_valid  input  1  upstream payload valid.
- input_port_ready  output  1  buffer can accept a word.
- output_port_data  output  DATA_WIDTH  payload at FIFO head.
- output_port_valid  output  1  head entry valid.
- output_port_ready  input  1  downstream accepts the head entry.
- level  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Interface: single clock clock_port; reset_port is synchronous and active-high.
- Reset: sampled high at a rising edge, it sets level=0, write pointer=0, read pointer=0, output_port_valid=0 and output_port_data=0.
  - While reset_port is high, input_port_ready=0 combinationally, and no push or pop takes effect.
  - Storage contents are not reset.
- Push: when input_port_valid && input_port_ready at an edge, store input_port_data at wr_ptr, then wr_ptr = (wr_ptr+1) mod DEPTH.
- Pop: when output_port_valid && output_port_ready at an edge, rd_ptr = (rd_ptr+1) mod DEPTH.
- input_port_ready = (level != DEPTH) && !reset_port.
  - It depends only on registered state and reset, never on output_port_ready.
  - When full, a simultaneous pop does not open ready in the same cycle; ready rises the cycle after the pop.
- output_port_valid = (level != 0), a registered-state function only.
- output_port_data = storage[rd_ptr].
  - It is held stable while output_port_valid && !output_port_ready.
  - When empty, its value is don't-care: after reset it is 0, otherwise the stale entry.
- Latency: a word pushed at edge N is visible on the output from cycle N+1. There is no fall-through and no bypass, even when empty.
- Occupancy update per edge:
  - push only: level+1.
  - pop only: level-1.
  - push and pop: level unchanged (possible for any 0 < level < DEPTH).
  - neither: level unchanged.
- Ordering: strict FIFO; no drops, no duplicates.
- Throughput: sustains 1 word/cycle with both sides continuously active, once level is between 1 and DEPTH-1.
- Boundaries:
  - Pointers wrap silently; level is the sole full/empty discriminator.
  - Push while full is impossible because ready is low. A valid held high by upstream stays pending and is not lost.
  - Pop while empty is impossible because valid is low.
- Upstream protocol: input_port_valid, once high, may not drop and input_port_data may not change until accepted. The buffer does not check this.
- Reset mid-operation discards all content: the cycle after reset deasserts shows output_port_valid=0 and level=0.

Test Plan:
- Reset → level=0, output_port_valid=0, output_port_data=0, input_port_ready=0 during reset and 1 the cycle after.
- Fill (DEPTH=4): push 0x11,0x22,0x33,0x44 on consecutive cycles with output_port_ready=0 → level 1,2,3,4; input_port_ready=0 after the 4th push; output_port_data=0x11 held stable throughout.
- Full with simultaneous pop: at level=4, raise output_port_ready for one cycle while input_port_valid stays high with 0x55 → 0x11 is popped, 0x55 is not accepted that cycle, ready returns next cycle, 0x55 is accepted the cycle after; final drain order is 0x22,0x33,0x44,0x55.
- Streaming: 16 words 0x00..0x0F with both sides always active → first output 1 cycle after the first push, then 1 word/cycle in order, level steady at 1, no gaps.
- Wrap-around with random stalls: 1000 random words under random valid/ready patterns (~50% each) → scoreboard matches in order, level never exceeds 4, no data change while stalled.
- Reset mid-stream: assert reset at level=3 for one cycle → level=0 and output_port_valid=0 next cycle; subsequent push 0xA5 appears as the first output.

Source files
------------

// File: rtl/rv_fifo_buffer.sv
// rv_fifo_buffer: registered ready/valid FIFO that decouples generator and checker, exposing occupancy
module rv_fifo_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                       clock_port,
    input  logic                       reset_port,
    input  logic [DATA_WIDTH-1:0]      input_port_data,
    input  logic                       input_port_valid,
    output logic                       input_port_ready,
    output logic [DATA_WIDTH-1:0]      output_port_data,
    output logic                       output_port_valid,
    input  logic                       output_port_ready,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [DATA_WIDTH-1:0] storage [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic zero_out;
    logic push, pop;
    // handshakes and status derive only from registered state and reset
    always_comb begin
        input_port_ready  = (level != FULL) && !reset_port;
        output_port_valid = level != '0;
        push              = input_port_valid && input_port_ready;
        pop               = output_port_valid && output_port_ready && !reset_port;
        output_port_data  = zero_out ? '0 : storage[rd_ptr];
    end
    // pointers and occupancy; output reads as zero after reset until the first write
    always_ff @(posedge clock_port) begin
        if (reset_port) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            zero_out <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                zero_out <= 1'b0;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
    // payload storage is never cleared
    always_ff @(posedge clock_port) begin
        if (push) storage[wr_ptr] <= input_port_data;
    end
endmodule
